// File: rtl/wf_btn_cond.sv
// wf_btn_cond: button conditioner for the waveform window stage.
// Sync, debounce, auto-repeat and chord-free one-hot command pulses.
module wf_btn_cond #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned REPEAT_DELAY    = 50000000,
   parameter int unsigned REPEAT_PERIOD   = 15000000,
   parameter logic [2:0]  REPEAT_EN       = 3'b110
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] btn_raw,
   output logic       btn1,
   output logic       btn2,
   output logic       btn3,
   output logic [2:0] held
);

   localparam int unsigned DW =
      (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned RMAX =
      (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned RW = $clog2(RMAX);

   localparam logic [DW-1:0] D_TERM   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] DLY_TERM = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] PER_TERM = RW'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_RPT  = 2'd2
   } rep_st_e;

   logic [2:0]    meta_q;
   logic [2:0]    sync_q;
   logic [2:0]    held_q;
   logic [2:0]    held_d;
   logic [2:0]    hprev_q;
   logic [DW-1:0] dcnt_q [3];
   logic [DW-1:0] dcnt_d [3];
   rep_st_e       st_q   [3];
   rep_st_e       st_d   [3];
   logic [RW-1:0] rcnt_q [3];
   logic [RW-1:0] rcnt_d [3];
   logic [2:0]    rise;
   logic [2:0]    ev;
   logic [2:0]    ev_f;
   logic          chord;
   logic [2:0]    pulse_q;

   // Two-flop synchronizer for the asynchronous raw buttons.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= btn_raw;
         sync_q <= meta_q;
      end
   end

   // Debounce: accept a new level only after it persists long enough.
   always_comb begin
      held_d = held_q;
      for (int i = 0; i < 3; i++) begin
         dcnt_d[i] = '0;
         if (sync_q[i] != held_q[i]) begin
            if (dcnt_q[i] == D_TERM) begin
               held_d[i] = sync_q[i];
            end else begin
               dcnt_d[i] = dcnt_q[i] + DW'(1);
            end
         end
      end
   end

   // Debounced level, its previous value and the debounce counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         held_q  <= '0;
         hprev_q <= '0;
         for (int i = 0; i < 3; i++) begin
            dcnt_q[i] <= '0;
         end
      end else begin
         held_q  <= held_d;
         hprev_q <= held_q;
         for (int i = 0; i < 3; i++) begin
            dcnt_q[i] <= dcnt_d[i];
         end
      end
   end

   assign rise = held_q & ~hprev_q;

   // Repeat FSM state register and repeat counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            st_q[i]   <= ST_IDLE;
            rcnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            st_q[i]   <= st_d[i];
            rcnt_q[i] <= rcnt_d[i];
         end
      end
   end

   // Repeat FSM next state; a release always wins over terminal count.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         st_d[i]   = st_q[i];
         rcnt_d[i] = '0;
         case (st_q[i])
            ST_HOLD: begin
               if (!held_q[i]) begin
                  st_d[i] = ST_IDLE;
               end else if (rcnt_q[i] == DLY_TERM) begin
                  st_d[i] = ST_RPT;
               end else begin
                  rcnt_d[i] = rcnt_q[i] + RW'(1);
               end
            end
            ST_RPT: begin
               if (!held_q[i]) begin
                  st_d[i] = ST_IDLE;
               end else if (rcnt_q[i] != PER_TERM) begin
                  rcnt_d[i] = rcnt_q[i] + RW'(1);
               end
            end
            default: begin
               st_d[i] = ST_IDLE;
               if (rise[i] && REPEAT_EN[i]) begin
                  st_d[i] = ST_HOLD;
               end
            end
         endcase
      end
   end

   // Repeat FSM outputs: press and repeat events per channel.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         ev[i] = 1'b0;
         case (st_q[i])
            ST_HOLD: ev[i] = held_q[i] && (rcnt_q[i] == DLY_TERM);
            ST_RPT:  ev[i] = held_q[i] && (rcnt_q[i] == PER_TERM);
            default: ev[i] = rise[i];
         endcase
      end
   end

   // Events only occur on held channels, so dropping chords keeps one-hot.
   assign chord = (held_q[0] & held_q[1]) |
                  (held_q[0] & held_q[2]) |
                  (held_q[1] & held_q[2]);
   assign ev_f  = chord ? 3'b000 : ev;

   // Registered single-cycle command pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pulse_q <= '0;
      end else begin
         pulse_q <= ev_f;
      end
   end

   assign btn1 = pulse_q[0];
   assign btn2 = pulse_q[1];
   assign btn3 = pulse_q[2];
   assign held = held_q;

endmodule

// File: doc/wf_btn_cond.md
# wf_btn_cond

Button conditioner feeding the waveform-window limits FSM. Synchronizes three raw push-button inputs, debounces each, and emits single-cycle one-hot command pulses on `btn1`/`btn2`/`btn3`, exactly the pulse form the window-stage FSM expects. Zoom-step buttons (`btn2`, `btn3`) auto-repeat while held. Chords are rejected so the downstream stage never sees a multi-button pattern.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive synchronized cycles a level change must persist before it is accepted. Must be >= 1.
- `REPEAT_DELAY`, default 50000000: cycles from the press pulse to the first repeat pulse. Must be >= 2.
- `REPEAT_PERIOD`, default 15000000: cycles between successive repeat pulses. Must be >= 2.
- `REPEAT_EN`, default 3'b110: per-channel auto-repeat enable, bit0 = btn1.
- `clk` in 1: system clock. One clock domain.
- `rst` in 1: reset, asynchronous, active-high.
- `btn_raw` in 3: raw, asynchronous, bouncing buttons, bit0 = btn1.
- `btn1` out 1: single-cycle pulse, full-screen toggle command.
- `btn2` out 1: single-cycle pulse, zoom-in step command.
- `btn3` out 1: single-cycle pulse, zoom-out step command.
- `held` out 3: debounced button levels.

## Operation
- **Reset values:** all synchronizer flops, `held`, the debounce counters, the repeat counters and the pulse outputs are 0. Every repeat FSM is IDLE.
- **Synchronizer:** 2 flops per channel, `btn_raw[i]` -> `s[i]`.
- **Debounce (per channel):** counter `dcnt`, width `$clog2(DEBOUNCE_CYCLES)` (minimum 1).
  - Each edge with `s != held`: if `dcnt == DEBOUNCE_CYCLES-1`, set `held <= s` and `dcnt <= 0`; otherwise `dcnt <= dcnt+1`.
  - Each edge with `s == held`: `dcnt <= 0`. A glitch shorter than `DEBOUNCE_CYCLES` therefore produces no change.
- **Event generation (per channel):** repeat FSM with states IDLE, HOLD and REPEAT, plus counter `rcnt`.
  - IDLE: a `held` rising edge raises event `ev[i]`. Go to HOLD if `REPEAT_EN[i]`, else stay in IDLE. `rcnt <= 0`.
  - HOLD: `rcnt` increments. At `rcnt == REPEAT_DELAY-1`, raise `ev[i]`, go to REPEAT, `rcnt <= 0`.
  - REPEAT: `rcnt` increments. At `rcnt == REPEAT_PERIOD-1`, raise `ev[i]` and set `rcnt <= 0`.
  - `held[i] == 0` in HOLD or REPEAT forces IDLE and `rcnt <= 0`, with no event. This takes priority over the terminal count.
- **Chord rejection:** when `held` has two or more bits set in a cycle, all `ev` of that cycle are discarded. The FSMs and counters still advance normally.
- **Outputs:** `{btn3,btn2,btn1}` are registered from the filtered `ev` and are always one-hot or zero.
- No event is emitted on release.

## Timing
- Press latency: `btn_raw[i]` is first sampled high at edge 0 and stays high. `s[i]` = 1 after edge 1, `held[i]` = 1 after edge `DEBOUNCE_CYCLES+1`, and the pulse is high for exactly one cycle after edge `DEBOUNCE_CYCLES+2`.
- Release latency: `held` falls `DEBOUNCE_CYCLES+1` edges after the first low sample.
- Repeat timing: with the press pulse at edge P, repeat pulses occur at P+`REPEAT_DELAY` and then every `REPEAT_PERIOD` edges while held.
- Any repeat counter at terminal count is discarded if the channel's `held` has already fallen.
- Reset mid-operation clears everything immediately, without waiting for a clock edge. A button held through reset release produces a fresh press pulse once it has passed the debounce again.
- Simultaneous rising edges on two channels produce no pulse on either. If one of them is released, the remaining held channel does not re-pulse; it only produces repeats if it is still in HOLD or REPEAT.

## Test plan
- **Clean press** (`DEBOUNCE_CYCLES`=4, `REPEAT_EN`=0): `btn_raw[0]` goes high at edge 0 and is held for 20 cycles -> `btn1` is high for exactly one cycle after edge 6; `held[0]` = 1 from edge 5; no further pulses.
- **Bounce:** `btn_raw[1]` toggles with 1–3 cycle pulses for 12 cycles, then stays stable high -> exactly one `btn2` pulse, 6 edges after the start of the stable level; shorter glitches produce no pulse.
- **Auto-repeat** (`REPEAT_DELAY`=8, `REPEAT_PERIOD`=3): `btn_raw[2]` is held for 40 cycles -> `btn3` pulses at P, P+8, P+11, P+14 and so on; pulses stop within one cycle of `held[2]` falling.
- **Chord:** `btn_raw[0]` and `btn_raw[1]` rise on the same edge -> no pulse on any output; `held` = 3'b011.
- **Chord overlap:** `btn2` is in REPEAT and `btn_raw[0]` is then pressed -> `btn2` repeats are suppressed while both are held.
- **Async reset:** assert `rst` mid-REPEAT between clock edges -> all outputs go to 0 immediately. Deassert with the button still down -> one new press pulse after `DEBOUNCE_CYCLES`+2 edges.
